// File: rtl/pinwheel_lsu_pkg.sv
// pinwheel_lsu_pkg: shared types and helpers for the pinwheel load/store unit.
// Build option PINWHEEL_LSU_MISALIGN_EN (see pinwheel_lsu.sv) does not affect this file.
package pinwheel_lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        CAP,
        RESP
    } lsu_state_e;

    // Byte lanes touched by an access: low nibble is word w, high nibble word w+1.
    function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/pinwheel_lsu_align.sv
// pinwheel_lsu_align: store-data lane rotation and load extract/extend.
// Purely combinational; used identically with or without PINWHEEL_LSU_MISALIGN_EN.
module pinwheel_lsu_align
    import pinwheel_lsu_pkg::*;
(
    input  logic [1:0]      off,
    input  size_e           size,
    input  logic            is_signed,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] store_data_c,
    output logic [XLEN-1:0] load_data_c
);

    logic [2*XLEN-1:0] pair;
    logic [XLEN-1:0]   shifted;

    // Rotate store data left so its byte 0 lands on lane `off`.
    always_comb begin
        case (off)
            2'd0:    store_data_c = wdata;
            2'd1:    store_data_c = {wdata[23:0], wdata[31:24]};
            2'd2:    store_data_c = {wdata[15:0], wdata[31:16]};
            default: store_data_c = {wdata[7:0],  wdata[31:8]};
        endcase
    end

    // Pull the addressed bytes out of the {hi, lo} window and extend them.
    always_comb begin
        pair    = {hi, lo};
        shifted = XLEN'(pair >> {off, 3'b000});
        case (size)
            BYTE:    load_data_c = {{24{is_signed & shifted[7]}},  shifted[7:0]};
            HALF:    load_data_c = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: load_data_c = shifted;
        endcase
    end

endmodule

// File: rtl/pinwheel_lsu.sv
// pinwheel_lsu: byte-addressed load/store front end for the word-organised pinwheel_mem.
// Define PINWHEEL_LSU_MISALIGN_EN to allow misaligned accesses (crossing ones split
// into two RAM cycles); without it any misaligned request is rejected with resp_err.
module pinwheel_lsu
    import pinwheel_lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH) + 2
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [AW-1:0]            req_addr,
    input  logic [1:0]               req_size,
    input  logic                     req_signed,
    input  logic [XLEN-1:0]          req_wdata,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [XLEN-1:0]          resp_rdata,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic                     mem_we,
    output logic [3:0]               mem_wmask,
    output logic [XLEN-1:0]          mem_wdata,
    output logic                     mem_re,
    input  logic [XLEN-1:0]          mem_rdata
);

    localparam int unsigned WAW = $clog2(DEPTH);

    lsu_state_e      state_q, state_d;
    logic            write_q, write_d;
    logic            signed_q, signed_d;
    size_e           size_q, size_d;
    logic [1:0]      off_q, off_d;
    logic [WAW-1:0]  word_q, word_d;
    logic [7:0]      mask_q, mask_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            req_ready_d, resp_valid_d, resp_err_d, mem_we_d, mem_re_d;
    logic [XLEN-1:0] resp_rdata_d, mem_wdata_d;
    logic [WAW-1:0]  mem_addr_d;
    logic [3:0]      mem_wmask_d;

    logic [7:0]      req_mask_c;
    logic            req_err_c;
    logic            split_c;
    logic [1:0]      align_off_c;
    logic [XLEN-1:0] cap_lo_c, cap_hi_c, store_data_c, load_data_c;

    // Request decode: lane vector and rejection of illegal sizes / misalignment.
    always_comb begin
        req_mask_c = lane_mask(req_addr[1:0], req_size);
`ifdef PINWHEEL_LSU_MISALIGN_EN
        req_err_c  = (req_size == SIZE_ILLEGAL);
`else
        case (req_size)
            2'd0:    req_err_c = 1'b0;
            2'd1:    req_err_c = req_addr[0];
            2'd2:    req_err_c = |req_addr[1:0];
            default: req_err_c = 1'b1;
        endcase
`endif
    end

    // Capture-side window: split loads keep word w in lo_q, the RAM supplies w+1.
    always_comb begin
        split_c     = |mask_q[7:4];
        align_off_c = (state_q == IDLE) ? req_addr[1:0] : off_q;
        cap_lo_c    = split_c ? lo_q : mem_rdata;
        cap_hi_c    = split_c ? mem_rdata : '0;
    end

    pinwheel_lsu_align u_align (
        .off          (align_off_c),
        .size         (size_q),
        .is_signed    (signed_q),
        .wdata        (req_wdata),
        .lo           (cap_lo_c),
        .hi           (cap_hi_c),
        .store_data_c (store_data_c),
        .load_data_c  (load_data_c)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        signed_d     = signed_q;
        size_d       = size_q;
        off_d        = off_q;
        word_d       = word_q;
        mask_d       = mask_q;
        lo_d         = lo_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_wmask_d  = '0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    write_d     = req_write;
                    signed_d    = req_signed;
                    off_d       = req_addr[1:0];
                    word_d      = req_addr[AW-1:2];
                    mask_d      = req_mask_c;
                    if (req_err_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d    = ACC0;
                        size_d     = size_e'(req_size);
                        mem_addr_d = req_addr[AW-1:2];
                        mem_we_d   = req_write;
                        mem_re_d   = !req_write;
                        if (req_write) begin
                            mem_wmask_d = req_mask_c[3:0];
                            mem_wdata_d = store_data_c;
                        end
                    end
                end
            end
            ACC0: begin
`ifdef PINWHEEL_LSU_MISALIGN_EN
                if (split_c) begin
                    state_d     = ACC1;
                    mem_addr_d  = word_q + WAW'(1);
                    mem_we_d    = write_q;
                    mem_re_d    = !write_q;
                    mem_wmask_d = write_q ? mask_q[7:4] : 4'b0000;
                end else
`endif
                if (write_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = CAP;
                end
            end
`ifdef PINWHEEL_LSU_MISALIGN_EN
            ACC1: begin
                if (write_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    lo_d    = mem_rdata;
                    state_d = CAP;
                end
            end
`endif
            CAP: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data_c;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= BYTE;
            off_q      <= '0;
            word_q     <= '0;
            mask_q     <= '0;
            lo_q       <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_wmask  <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            signed_q   <= signed_d;
            size_q     <= size_d;
            off_q      <= off_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            lo_q       <= lo_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_addr   <= mem_addr_d;
            mem_we     <= mem_we_d;
            mem_re     <= mem_re_d;
            mem_wmask  <= mem_wmask_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule
